// File: rtl/fm_avalon_pipe.sv
// -----------------------------------------------------------------------------
// fm_avalon_pipe
//   Pipelined Avalon-MM slave bridge onto the internal req/ack/rstr register
//   bus. Reads and writes share one in-order command FIFO. Several reads may
//   be outstanding, and read data is returned on Avalon through
//   readdatavalid.
//
// Ports
//   clk_core              core clock (the only clock)
//   rst_x                 asynchronous active-low reset
//   i_av_adr/be/r/w/wd    Avalon request (address, byte enables, read, write,
//                         write data)
//   o_av_wait             Avalon waitrequest
//   o_av_rd/o_av_rdv      Avalon read data / readdatavalid
//   o_req/o_wr/o_adrs/    internal command: the FIFO head, held stable
//   o_be/o_wd             until i_ack
//   i_ack                 internal command accept (pops the FIFO head)
//   i_rstr/i_rd           internal read-data strobe and data, returned in
//                         issue order
//   o_idle                FIFO empty and no reads outstanding
// -----------------------------------------------------------------------------
module fm_avalon_pipe #(
  parameter int P_AVALON_ADR_WIDTH  = 10,
  parameter int P_AVALON_BE_WIDTH   = 4,
  parameter int P_AVALON_DATA_WIDTH = 32,
  parameter int P_FIFO_DEPTH_LOG2   = 2,
  parameter int P_MAX_RD            = 4
) (
  input  logic                           clk_core,
  input  logic                           rst_x,
  input  logic [P_AVALON_ADR_WIDTH-1:0]  i_av_adr,
  input  logic [P_AVALON_BE_WIDTH-1:0]   i_av_be,
  input  logic                           i_av_r,
  input  logic                           i_av_w,
  input  logic [P_AVALON_DATA_WIDTH-1:0] i_av_wd,
  output logic                           o_av_wait,
  output logic [P_AVALON_DATA_WIDTH-1:0] o_av_rd,
  output logic                           o_av_rdv,
  output logic                           o_req,
  output logic                           o_wr,
  output logic [P_AVALON_ADR_WIDTH-1:0]  o_adrs,
  output logic [P_AVALON_BE_WIDTH-1:0]   o_be,
  output logic [P_AVALON_DATA_WIDTH-1:0] o_wd,
  input  logic                           i_ack,
  input  logic                           i_rstr,
  input  logic [P_AVALON_DATA_WIDTH-1:0] i_rd,
  output logic                           o_idle
);

  localparam int D  = 1 << P_FIFO_DEPTH_LOG2;
  localparam int PW = P_FIFO_DEPTH_LOG2 + 1;          // extra bit separates full from empty
  localparam int CW = $clog2(P_MAX_RD + 1);
  localparam int EW = 1 + P_AVALON_ADR_WIDTH + P_AVALON_BE_WIDTH + P_AVALON_DATA_WIDTH;

  // Entry layout: {wr, adr, be, wd}
  logic [EW-1:0] mem_q [D];
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] push_entry;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [P_AVALON_DATA_WIDTH-1:0] av_rd_q, av_rd_d;
  logic          av_rdv_q, av_rdv_d;

  logic fifo_empty, fifo_full, rd_at_max;
  logic push, pop, rd_acc, rstr_ok;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign rd_at_max  = (rd_cnt_q == CW'(P_MAX_RD));

  // A simultaneous read+write is taken as a write, so only a pure read is
  // throttled by the outstanding-read limit.
  assign o_av_wait  = fifo_full | (i_av_r & ~i_av_w & rd_at_max);
  assign push       = (i_av_r | i_av_w) & ~o_av_wait;
  assign rd_acc     = push & i_av_r & ~i_av_w;
  assign push_entry = {i_av_w, i_av_adr, i_av_be, i_av_wd};

  assign o_req      = ~fifo_empty;
  assign pop        = o_req & i_ack;

  // Strobes with nothing outstanding are spurious and dropped.
  assign rstr_ok    = i_rstr & (rd_cnt_q != '0);

  assign o_idle     = fifo_empty & (rd_cnt_q == '0);

  assign {o_wr, o_adrs, o_be, o_wd} = head_q;
  assign o_av_rd  = av_rd_q;
  assign o_av_rdv = av_rdv_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    // The head is kept in its own register so the internal command outputs
    // come straight from flops. It is reloaded whenever the FIFO changes and
    // stays non-empty. If the next head is the entry being written this
    // cycle, take it from the input, since the array write has not landed
    // yet.
    head_d = head_q;
    if ((push | pop) && (rd_ptr_d != wr_ptr_d)) begin
      if (rd_ptr_d == wr_ptr_q) begin
        head_d = push_entry;
      end else begin
        head_d = mem_q[rd_ptr_d[PW-2:0]];
      end
    end

    unique case ({rd_acc, rstr_ok})
      2'b10:   rd_cnt_d = rd_cnt_q + CW'(1);
      2'b01:   rd_cnt_d = rd_cnt_q - CW'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase

    av_rdv_d = rstr_ok;
    av_rd_d  = rstr_ok ? i_rd : av_rd_q;
  end

  // Command storage. It needs no reset because the pointers gate every read.
  always_ff @(posedge clk_core) begin
    if (push) begin
      mem_q[wr_ptr_q[PW-2:0]] <= push_entry;
    end
  end

  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_cnt_q <= '0;
      head_q   <= '0;
      av_rd_q  <= '0;
      av_rdv_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_cnt_q <= rd_cnt_d;
      head_q   <= head_d;
      av_rd_q  <= av_rd_d;
      av_rdv_q <= av_rdv_d;
    end
  end

endmodule

// File: tb/tb_fm_avalon_pipe.sv
// -----------------------------------------------------------------------------
// tb_fm_avalon_pipe
//   Scoreboard bench for fm_avalon_pipe.
//   - The Avalon driver records an expected internal command for each
//     accepted access.
//   - For each accepted read it also records an expected read word, taken
//     from a plain word-memory reference model.
//   - A behavioural internal slave answers o_req with i_ack and returns read
//     data with i_rstr after configurable delays.
//   - Independent monitors pop the queues whenever the DUT issues a command
//     or returns data.
// -----------------------------------------------------------------------------
module tb_fm_avalon_pipe;

  localparam int AW = 10;
  localparam int BW = 4;
  localparam int DW = 32;
  localparam int D  = 4;
  localparam int MAXRD = 4;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] adr;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
  } cmd_t;

  logic          clk_core = 1'b0;
  logic          rst_x;
  logic [AW-1:0] i_av_adr;
  logic [BW-1:0] i_av_be;
  logic          i_av_r, i_av_w;
  logic [DW-1:0] i_av_wd;
  logic          o_av_wait;
  logic [DW-1:0] o_av_rd;
  logic          o_av_rdv;
  logic          o_req, o_wr;
  logic [AW-1:0] o_adrs;
  logic [BW-1:0] o_be;
  logic [DW-1:0] o_wd;
  logic          i_ack, i_rstr;
  logic [DW-1:0] i_rd;
  logic          o_idle;

  fm_avalon_pipe #(
    .P_AVALON_ADR_WIDTH (AW),
    .P_AVALON_BE_WIDTH  (BW),
    .P_AVALON_DATA_WIDTH(DW),
    .P_FIFO_DEPTH_LOG2  (2),
    .P_MAX_RD           (MAXRD)
  ) dut (
    .clk_core (clk_core),
    .rst_x    (rst_x),
    .i_av_adr (i_av_adr),
    .i_av_be  (i_av_be),
    .i_av_r   (i_av_r),
    .i_av_w   (i_av_w),
    .i_av_wd  (i_av_wd),
    .o_av_wait(o_av_wait),
    .o_av_rd  (o_av_rd),
    .o_av_rdv (o_av_rdv),
    .o_req    (o_req),
    .o_wr     (o_wr),
    .o_adrs   (o_adrs),
    .o_be     (o_be),
    .o_wd     (o_wd),
    .i_ack    (i_ack),
    .i_rstr   (i_rstr),
    .i_rd     (i_rd),
    .o_idle   (o_idle)
  );

  always #5 clk_core = ~clk_core;

  int cyc = 0;
  always @(posedge clk_core) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model and scoreboards ----------------
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] smem    [1024];
  cmd_t          exp_cmd [$];
  logic [DW-1:0] exp_rd  [$];
  int            pop_cycles  [$];
  int            rstr_cycles [$];
  logic [DW-1:0] last_rdv;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // ---------------- internal-side behavioural slave ----------------
  bit            ack_hold  = 1'b0;
  int            ack_fixed = 0;      // -1 selects a random ack delay
  int            cur_dly   = 0;
  int            req_age   = 0;
  bit            rstr_hold = 1'b0;
  bit            rstr_rand = 1'b0;
  bit            spur_rstr = 1'b0;
  logic [DW-1:0] pend_data [$];
  int            pend_due  [$];

  function automatic int pick_dly();
    return (ack_fixed < 0) ? int'($urandom_range(0, 3)) : ack_fixed;
  endfunction

  initial begin
    i_ack = 1'b0; i_rstr = 1'b0; i_rd = '0;
    forever begin
      @(posedge clk_core); #1;
      i_ack  = 1'b0;
      i_rstr = 1'b0;
      if (rst_x) begin
        if (o_req && !ack_hold) begin
          if (req_age >= cur_dly) begin
            i_ack = 1'b1;
            if (o_wr) smem[o_adrs] = merge(smem[o_adrs], o_wd, o_be);
            else begin
              pend_data.push_back(smem[o_adrs]);
              pend_due.push_back(cyc + (rstr_rand ? int'($urandom_range(0, 3)) : 0));
            end
            req_age = 0;
            cur_dly = pick_dly();
          end else req_age++;
        end else if (!o_req) req_age = 0;

        if (spur_rstr) begin
          i_rstr = 1'b1; i_rd = $urandom; spur_rstr = 1'b0;
        end else if (!rstr_hold && pend_data.size() > 0 && pend_due[0] <= cyc) begin
          i_rstr = 1'b1; i_rd = pend_data.pop_front(); void'(pend_due.pop_front());
        end
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk_core) begin
    if (rst_x) begin
      if (o_req && i_ack) begin
        cmd_t e;
        pop_cycles.push_back(cyc);
        if (exp_cmd.size() == 0) chk("cmd_unexpected", {o_wr, o_adrs}, 64'h0);
        else begin
          e = exp_cmd.pop_front();
          chk("cmd", {o_wr, o_adrs, o_be, (o_wr ? o_wd : 32'h0)}, e);
        end
      end
      if (i_rstr) rstr_cycles.push_back(cyc);
      if (o_av_rdv) begin
        last_rdv = o_av_rd;
        if (exp_rd.size() == 0) chk("rdv_unexpected", {31'h0, o_av_rdv}, 64'h0);
        else chk("rdata", o_av_rd, exp_rd.pop_front());
      end
    end
  end

  // ---------------- Avalon driver ----------------
  task automatic av_access(input logic r, input logic w, input logic [AW-1:0] adr,
                           input logic [BW-1:0] be, input logic [DW-1:0] wd,
                           output int acc_cyc, output int waited);
    bit done;
    done = 1'b0; waited = 0; acc_cyc = -1;
    i_av_r = r; i_av_w = w; i_av_adr = adr; i_av_be = be; i_av_wd = wd;
    while (!done) begin
      @(negedge clk_core);
      if (!o_av_wait) begin
        done = 1'b1; acc_cyc = cyc;
        if (w) begin
          exp_cmd.push_back({1'b1, adr, be, wd});
          ref_mem[adr] = merge(ref_mem[adr], wd, be);
        end else begin
          exp_cmd.push_back({1'b0, adr, be, 32'h0});
          exp_rd.push_back(ref_mem[adr]);
        end
      end else if (waited >= 300) begin
        chk("accept_timeout", 64'd1, 64'd0); done = 1'b1;
      end else waited++;
      @(posedge clk_core); #1;
    end
    i_av_r = 1'b0; i_av_w = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (o_idle && exp_cmd.size() == 0 && exp_rd.size() == 0 && pend_data.size() == 0) begin
        ok = 1'b1; break;
      end
      @(posedge clk_core); #1;
    end
    chk(name, {63'h0, ok}, 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wait"},  {63'h0, o_av_wait}, 64'd0);
    chk({tag, "_rd"},    o_av_rd,            64'd0);
    chk({tag, "_rdv"},   {63'h0, o_av_rdv},  64'd0);
    chk({tag, "_req"},   {63'h0, o_req},     64'd0);
    chk({tag, "_wr"},    {63'h0, o_wr},      64'd0);
    chk({tag, "_adrs"},  o_adrs,             64'd0);
    chk({tag, "_be"},    o_be,               64'd0);
    chk({tag, "_wd"},    o_wd,               64'd0);
    chk({tag, "_idle"},  {63'h0, o_idle},    64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc, wt, acc2, wt2, first;
    for (int a = 0; a < 1024; a++) begin ref_mem[a] = DW'(a); smem[a] = DW'(a); end
    rst_x = 1'b0; i_av_r = 1'b0; i_av_w = 1'b0; i_av_adr = '0; i_av_be = '0; i_av_wd = '0;
    repeat (3) @(posedge clk_core); #1;
    chk_reset_outputs("reset");
    rst_x = 1'b1;
    @(posedge clk_core); #1;

    // Single write with an immediate ack.
    ack_fixed = 0; cur_dly = 0;
    av_access(1'b0, 1'b1, 10'h015, 4'hF, 32'hDEADBEEF, acc, wt);
    chk("t1_req",  {63'h0, o_req}, 64'd1);
    chk("t1_wr",   {63'h0, o_wr},  64'd1);
    chk("t1_adrs", o_adrs, 64'h015);
    chk("t1_be",   o_be,   64'hF);
    chk("t1_wd",   o_wd,   64'hDEADBEEF);
    chk("t1_busy", {63'h0, o_idle}, 64'd0);
    @(posedge clk_core); #1;
    chk("t1_idle", {63'h0, o_idle}, 64'd1);
    wait_idle("t1_drain");

    // D+1 writes against a stalled internal side.
    ack_hold = 1'b1;
    for (int i = 0; i < D; i++) begin
      av_access(1'b0, 1'b1, AW'(10'h100 + i), 4'hF, $urandom, acc, wt);
      chk("t2_nowait", wt, 64'd0);
    end
    pop_cycles.delete();
    fork
      av_access(1'b0, 1'b1, 10'h104, 4'hF, 32'h0BAD_F00D, acc, wt);
      begin repeat (3) @(posedge clk_core); ack_hold = 1'b0; end
    join
    first = (pop_cycles.size() > 0) ? pop_cycles[0] : -100;
    chk("t2_waited", {63'h0, wt > 0}, 64'd1);
    chk("t2_acc_after_pop", acc, 64'(first + 1));
    wait_idle("t2_drain");

    // Five reads against a limit of four, with the return path held off.
    rstr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      av_access(1'b1, 1'b0, AW'(i), 4'hF, 32'h0, acc, wt);
      chk("t3_nowait", wt, 64'd0);
    end
    rstr_cycles.delete();
    fork
      av_access(1'b1, 1'b0, 10'h005, 4'hF, 32'h0, acc, wt);
      begin repeat (4) @(posedge clk_core); rstr_hold = 1'b0; end
    join
    first = (rstr_cycles.size() > 0) ? rstr_cycles[0] : -100;
    chk("t3_waited", {63'h0, wt > 0}, 64'd1);
    chk("t3_acc_after_rstr", acc, 64'(first + 1));
    wait_idle("t3_drain");
    chk("t3_last", last_rdv, 64'h5);

    // Write then read of the same word through a slow-acking slave.
    ack_fixed = 3; cur_dly = 3;
    av_access(1'b0, 1'b1, 10'h020, 4'hF, 32'hA5A5A5A5, acc, wt);
    av_access(1'b1, 1'b0, 10'h020, 4'hF, 32'h0, acc2, wt2);
    wait_idle("t4_drain");
    chk("t4_rd", last_rdv, 64'hA5A5A5A5);

    // Randomized traffic with random ack and return delays.
    ack_fixed = -1; rstr_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      int op;
      op = int'($urandom_range(0, 2));
      if (op == 0)
        av_access(1'b0, 1'b1, AW'(10'h040 + $urandom_range(0, 15)), BW'($urandom), $urandom, acc, wt);
      else if (op == 1)
        av_access(1'b1, 1'b0, AW'(10'h040 + $urandom_range(0, 15)), BW'($urandom), 32'h0, acc, wt);
      else begin
        @(posedge clk_core); #1;
      end
    end
    wait_idle("rand_drain");
    ack_fixed = 0; cur_dly = 0; rstr_rand = 1'b0;

    // Spurious strobe, then a read+write collision taken as a write.
    rstr_cycles.delete();
    spur_rstr = 1'b1;
    repeat (3) begin
      @(posedge clk_core); #1;
      chk("t5_idle", {63'h0, o_idle}, 64'd1);
    end
    chk("t5_spur_seen", rstr_cycles.size(), 64'd1);
    av_access(1'b1, 1'b1, 10'h030, 4'hF, 32'h12345678, acc, wt);
    wait_idle("t5_rw_drain");
    chk("t5_rw_idle", {63'h0, o_idle}, 64'd1);

    // Reset with two queued commands and one outstanding read.
    rstr_hold = 1'b1;
    av_access(1'b1, 1'b0, 10'h001, 4'hF, 32'h0, acc, wt);
    repeat (2) begin @(posedge clk_core); #1; end
    ack_hold = 1'b1;
    av_access(1'b0, 1'b1, 10'h200, 4'hF, 32'h11111111, acc, wt);
    av_access(1'b0, 1'b1, 10'h201, 4'hF, 32'h22222222, acc, wt);
    chk("t6_busy", {63'h0, o_idle}, 64'd0);
    rst_x = 1'b0;
    #1;
    chk_reset_outputs("t6_reset");
    exp_cmd.delete(); exp_rd.delete(); pend_data.delete(); pend_due.delete();
    rstr_hold = 1'b0; ack_hold = 1'b0;
    @(posedge clk_core); #1;
    rst_x = 1'b1;
    spur_rstr = 1'b1;
    repeat (3) begin
      @(posedge clk_core); #1;
      chk("t6_no_rdv", {63'h0, o_av_rdv}, 64'd0);
      chk("t6_idle",   {63'h0, o_idle},   64'd1);
    end

    chk("final_cmdq", exp_cmd.size(), 64'd0);
    chk("final_rdq",  exp_rd.size(),  64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
